// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and sizing helpers for the register dump block
package debug_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SET_ADDR = 3'd1,
        S_LATCH    = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT     = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } dump_state_e;

    localparam int NB_DEFAULT      = 32;
    localparam int BYTE_NB_DEFAULT = 8;
    localparam int BYTES_PER_WORD  = NB_DEFAULT / BYTE_NB_DEFAULT;
    localparam int BYTE_CNT_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    // Counter width that stays legal for a single-byte word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - splits one captured word into MSB-first bytes for UART TX
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int NB      = NB_DEFAULT,
    parameter int BYTE_NB = BYTE_NB_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB-1:0]      word,
    input  logic               send,
    input  logic               waiting,
    input  logic               advance,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [BYTE_NB-1:0] tx_data,
    output logic               byte_taken,
    output logic               word_done
);

    localparam int BPW = NB / BYTE_NB;
    localparam int CW  = cnt_width(BPW);

    logic [NB-1:0] shift_reg;
    logic [CW-1:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (load) begin
            shift_reg <= word;
            byte_cnt  <= '0;
        end else begin
            if (byte_taken)
                shift_reg <= shift_reg << BYTE_NB;
            if (advance && !word_done)
                byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // A done pulse only counts while waiting, so one coincident with tx_start is dropped.
    assign byte_taken = waiting && tx_done;
    assign tx_start   = send;
    assign tx_data    = shift_reg[NB-1 -: BYTE_NB];
    assign word_done  = (byte_cnt == CW'(BPW - 1));

endmodule

// File: rtl/debug_regfile_dump.sv
// rtl/debug_regfile_dump.sv - walks the register file debug port and streams every word to UART TX
module debug_regfile_dump
    import debug_pkg::*;
#(
    parameter int NB       = 32,
    parameter int REGS     = 5,
    parameter int NUM_REGS = 32,
    parameter int BYTE_NB  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_start,
    input  logic [NB-1:0]      i_reg_data,
    input  logic               i_tx_done,
    output logic [REGS-1:0]    o_select_reg_dir,
    output logic               o_tx_start,
    output logic [BYTE_NB-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [REGS-1:0] LAST_REG = REGS'(NUM_REGS - 1);

    dump_state_e     state, state_nxt;
    logic [REGS-1:0] reg_cnt;
    logic            byte_taken;
    logic            word_done;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            reg_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && i_dump_start)
                reg_cnt <= '0;
            else if (state == S_NEXT && word_done && reg_cnt < LAST_REG)
                reg_cnt <= reg_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (i_dump_start) state_nxt = S_SET_ADDR;
            S_SET_ADDR: state_nxt = S_LATCH;
            S_LATCH:    state_nxt = S_SEND;
            S_SEND:     state_nxt = S_WAIT;
            S_WAIT:     if (byte_taken) state_nxt = S_NEXT;
            S_NEXT: begin
                if (!word_done)
                    state_nxt = S_SEND;
                else if (reg_cnt < LAST_REG)
                    state_nxt = S_SET_ADDR;
                else
                    state_nxt = S_DONE;
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // reg_cnt only moves on entry to SET_ADDR, so it doubles as the held read address.
    assign o_select_reg_dir = reg_cnt;
    assign o_busy           = (state != S_IDLE);
    assign o_done           = (state == S_DONE);

    debug_word_serializer #(
        .NB      (NB),
        .BYTE_NB (BYTE_NB)
    ) u_serializer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .load       (state == S_LATCH),
        .word       (i_reg_data),
        .send       (state == S_SEND),
        .waiting    (state == S_WAIT),
        .advance    (state == S_NEXT),
        .tx_done    (i_tx_done),
        .tx_start   (o_tx_start),
        .tx_data    (o_tx_data),
        .byte_taken (byte_taken),
        .word_done  (word_done)
    );

endmodule

// File: tb/tb_debug_regfile_dump.sv
// tb/tb_debug_regfile_dump.sv - self-checking bench for debug_regfile_dump
module tb_debug_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   rnd_delay = 1'b0;

    // Instance A: default 32 registers
    logic        start_a, spur_a, mock_done_a, tx_done_a;
    logic [31:0] rdata_a;
    logic [4:0]  sel_a;
    logic        txs_a, busy_a, done_a;
    logic [7:0]  txd_a;
    logic [31:0] mem_a [32];

    // Instance B: 4 registers
    logic        start_b, mock_done_b, tx_done_b;
    logic [31:0] rdata_b;
    logic [4:0]  sel_b;
    logic        txs_b, busy_b, done_b;
    logic [7:0]  txd_b;
    logic [31:0] mem_b [4];

    assign tx_done_a = mock_done_a | spur_a;
    assign tx_done_b = mock_done_b;

    debug_regfile_dump dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_dump_start     (start_a),
        .i_reg_data       (rdata_a),
        .i_tx_done        (tx_done_a),
        .o_select_reg_dir (sel_a),
        .o_tx_start       (txs_a),
        .o_tx_data        (txd_a),
        .o_busy           (busy_a),
        .o_done           (done_a)
    );

    debug_regfile_dump #(.NUM_REGS(4)) dut4 (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_dump_start     (start_b),
        .i_reg_data       (rdata_b),
        .i_tx_done        (tx_done_b),
        .o_select_reg_dir (sel_b),
        .o_tx_start       (txs_b),
        .o_tx_data        (txd_b),
        .o_busy           (busy_b),
        .o_done           (done_b)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rdata_a <= mem_a[sel_a];
        rdata_b <= mem_b[sel_b[1:0]];
    end

    // Mock UART: done pulse a fixed or random number of cycles after each tx_start
    int cnt_a = 0, cnt_b = 0;
    always @(negedge clk) begin
        mock_done_a = 1'b0;
        mock_done_b = 1'b0;
        if (!rst_n) begin
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (txs_a) cnt_a = rnd_delay ? int'($urandom_range(1, 6)) : 4;
            else if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0) mock_done_a = 1'b1;
            end
            if (txs_b) cnt_b = 4;
            else if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) mock_done_b = 1'b1;
            end
        end
    end

    // Monitors
    logic [7:0] bytes_a [$];
    logic [4:0] sels_a [$];
    logic [7:0] bytes_b [$];
    int first_cyc_a = -1;
    int done_cnt_a = 0, done_cnt_b = 0;
    always @(negedge clk) begin
        if (txs_a) begin
            if (bytes_a.size() == 0) first_cyc_a = cyc;
            bytes_a.push_back(txd_a);
            sels_a.push_back(sel_a);
        end
        if (done_a) done_cnt_a++;
        if (txs_b) bytes_b.push_back(txd_b);
        if (done_b) done_cnt_b++;
    end

    // Reference: big-endian byte stream of the register contents
    logic [7:0] exp_q [$];
    task automatic build_exp(input int nregs, input bit use_b, input int copies);
        exp_q.delete();
        for (int c = 0; c < copies; c++)
            for (int k = 0; k < nregs; k++)
                for (int b = 0; b < 4; b++)
                    exp_q.push_back(8'((use_b ? mem_b[k] : mem_a[k]) >> (8 * (3 - b))));
    endtask

    function automatic int first_diff_a();
        if (bytes_a.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (bytes_a[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_a();
        bytes_a.delete();
        sels_a.delete();
        first_cyc_a = -1;
        done_cnt_a  = 0;
    endtask

    task automatic pulse_a(output int c0);
        tick();
        start_a = 1'b1;
        c0 = cyc;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            tick();
            if (done_cnt_a >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({txs_a, txd_a, busy_a, done_a, sel_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx_start=%0b tx_data=%h busy=%0b done=%0b sel=%0d, need all 0",
                     txs_a, txd_a, busy_a, done_a, sel_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0 || txs_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b tx_start=%0b, need 0 0", busy_a, txs_a);
        end
    endtask

    task automatic test_basic();
        int c0, d;
        bit ok, sel_ok;
        for (int k = 0; k < 32; k++) mem_a[k] = 32'hA500_0000 + k;
        build_exp(32, 1'b0, 1);
        clear_a();
        pulse_a(c0);
        wait_done_a(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: got done_cnt=%0d, need 1", done_cnt_a);
        end
        checks++;
        if (first_cyc_a !== c0 + 3) begin
            errors++;
            $display("FAIL first_tx_latency: got c%0d, need c3", first_cyc_a - c0);
        end
        d = first_diff_a();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_stream: count=%0d idx=%0d, need 128 bytes matching model", bytes_a.size(), d);
        end
        sel_ok = (sels_a.size() == 128);
        foreach (sels_a[i]) if (sels_a[i] !== 5'(i / 4)) sel_ok = 1'b0;
        checks++;
        if (!sel_ok) begin
            errors++;
            $display("FAIL addr_sequence: sel did not step 0..31 once per 4 bytes (n=%0d)", sels_a.size());
        end
        checks++;
        if (sel_a !== 5'd31) begin
            errors++;
            $display("FAIL sel_held_in_done: got %0d, need 31", sel_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0 || done_cnt_a != 1) begin
            errors++;
            $display("FAIL basic_end: busy=%0b done_cnt=%0d, need 0 and 1", busy_a, done_cnt_a);
        end
    endtask

    task automatic test_random();
        int c0, d;
        bit ok;
        for (int k = 0; k < 32; k++) mem_a[k] = $urandom;
        build_exp(32, 1'b0, 1);
        rnd_delay = 1'b1;
        clear_a();
        pulse_a(c0);
        wait_done_a(1, ok);
        rnd_delay = 1'b0;
        d = first_diff_a();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL random_stream: ok=%0b count=%0d idx=%0d, need 128 matching bytes", ok, bytes_a.size(), d);
        end
        tick();
    endtask

    task automatic test_busy_start();
        int c0, d;
        bit ok;
        for (int k = 0; k < 32; k++) mem_a[k] = 32'hA500_0000 + k;
        build_exp(32, 1'b0, 1);
        clear_a();
        pulse_a(c0);
        for (int n = 0; n < 2000 && bytes_a.size() < 10; n++) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a(1, ok);
        repeat (20) tick();
        d = first_diff_a();
        checks++;
        if (!ok || d != -1 || done_cnt_a != 1) begin
            errors++;
            $display("FAIL busy_start: count=%0d idx=%0d done_cnt=%0d, need 128 bytes and 1 done",
                     bytes_a.size(), d, done_cnt_a);
        end
    endtask

    task automatic test_spurious_done();
        int c0, d;
        bit ok;
        build_exp(32, 1'b0, 1);
        clear_a();
        tick();
        spur_a = 1'b1;
        tick();
        spur_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: busy=%0b, need 0", busy_a);
        end
        pulse_a(c0);
        for (int n = 0; n < 20000 && done_cnt_a == 0; n++) begin
            tick();
            spur_a = txs_a && (bytes_a.size() == 1 || bytes_a.size() == 7 || bytes_a.size() == 50);
        end
        spur_a = 1'b0;
        d = first_diff_a();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL spurious_stream: count=%0d idx=%0d, need 128 bytes unchanged", bytes_a.size(), d);
        end
        tick();
    endtask

    task automatic test_reset_mid_dump();
        int c0, d;
        bit ok;
        build_exp(32, 1'b0, 1);
        clear_a();
        pulse_a(c0);
        for (int n = 0; n < 2000 && bytes_a.size() < 21; n++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txs_a, txd_a, busy_a, done_a, sel_a} !== '0) begin
            errors++;
            $display("FAIL reset_async: tx_start=%0b tx_data=%h busy=%0b done=%0b sel=%0d, need all 0",
                     txs_a, txd_a, busy_a, done_a, sel_a);
        end
        repeat (6) tick();
        checks++;
        if (bytes_a.size() != 21 || done_cnt_a != 0) begin
            errors++;
            $display("FAIL reset_abort: bytes=%0d done_cnt=%0d, need 21 and 0", bytes_a.size(), done_cnt_a);
        end
        rst_n = 1'b1;
        tick();
        clear_a();
        pulse_a(c0);
        wait_done_a(1, ok);
        checks++;
        if (bytes_a.size() == 0 || bytes_a[0] !== 8'hA5 || sels_a[0] !== 5'd0) begin
            errors++;
            $display("FAIL restart_first: byte=%h sel=%0d, need A5 at register 0",
                     bytes_a.size() ? bytes_a[0] : 8'h00, sels_a.size() ? sels_a[0] : 5'd0);
        end
        d = first_diff_a();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL restart_stream: count=%0d idx=%0d, need 128 matching", bytes_a.size(), d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        bit same;
        for (int k = 0; k < 4; k++) mem_b[k] = 32'hA500_0000 + k;
        build_exp(4, 1'b1, 2);
        bytes_b.delete();
        done_cnt_b = 0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 2000 && done_cnt_b < 1; n++) tick();
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done_cnt_b >= 2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        same = (bytes_b.size() == exp_q.size());
        if (same) foreach (exp_q[i]) if (bytes_b[i] !== exp_q[i]) same = 1'b0;
        checks++;
        if (!ok || !same || done_cnt_b != 2) begin
            errors++;
            $display("FAIL back_to_back: bytes=%0d done_cnt=%0d, need 32 matching and 2", bytes_b.size(), done_cnt_b);
        end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle: busy=%0b, need 0", busy_b);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        spur_a  = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k < 32; k++) mem_a[k] = '0;
        for (int k = 0; k < 4; k++) mem_b[k] = '0;
        test_reset();
        test_basic();
        test_random();
        test_busy_start();
        test_spurious_done();
        test_reset_mid_dump();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_regfile_dump.md
Name: debug_regfile_dump

Overview:
- Debug-side reader of the register file's debug read port.
- On a dump command it walks register addresses 0..NUM_REGS-1 and drives each address onto the register file's debug select input.
- It captures each returned word and serializes it into bytes for the UART transmitter, using a start/done handshake.
- It sits between the register file's debug read port and the debug unit's UART TX.

Parameters:
- NB, 32, register data width in bits; must be a multiple of 8.
- REGS, 5, register address width.
- NUM_REGS, 32, number of registers dumped; must be at most 2**REGS.
- BYTE_NB, 8, UART byte width.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_dump_start  in  1  single-cycle pulse that requests a full dump.
- i_reg_data  in  NB  debug read data from the register file, registered read with 1-cycle latency.
- i_tx_done  in  1  single-cycle pulse from the UART TX when the current byte is finished.
- o_select_reg_dir  out  REGS  debug read address to the register file.
- o_tx_start  out  1  single-cycle pulse; o_tx_data is valid in the same cycle.
- o_tx_data  out  BYTE_NB  byte to transmit.
- o_busy  out  1  high while a dump is in progress.
- o_done  out  1  single-cycle pulse after the last byte of the last register.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE.
  - o_select_reg_dir=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0.
  - Internal registers are cleared: reg counter, byte counter and the shift register.
  - Reset mid-dump aborts the dump; no further tx_start is issued.
- FSM states: IDLE, SET_ADDR, LATCH, SEND, WAIT, NEXT, DONE.
- IDLE:
  - o_busy=0.
  - i_dump_start=1 clears reg_cnt to 0 and moves to SET_ADDR.
- SET_ADDR:
  - o_select_reg_dir=reg_cnt; o_busy=1.
  - Always moves to LATCH.
- LATCH:
  - shift_reg <= i_reg_data; byte_cnt <= 0.
  - Moves to SEND.
- SEND:
  - o_tx_start=1 for exactly this cycle.
  - o_tx_data = shift_reg[NB-1 -: 8], so bytes go out MSB first (big-endian).
  - Moves to WAIT.
- WAIT:
  - Holds o_tx_data stable.
  - On i_tx_done, shift_reg shifts left by 8 and moves to NEXT.
- NEXT:
  - If byte_cnt < NB/8-1: byte_cnt++ and go to SEND.
  - Else if reg_cnt < NUM_REGS-1: reg_cnt++ and go to SET_ADDR.
  - Else go to DONE.
- DONE:
  - o_done=1 for one cycle.
  - Returns to IDLE; o_busy drops in the IDLE cycle.
- o_select_reg_dir holds its value from SET_ADDR until the next SET_ADDR, including during DONE and IDLE.
- Latency from i_dump_start sampled at cycle 0:
  - SET_ADDR at c1, LATCH at c2.
  - First o_tx_start at c3.
- Per byte: 3 cycles plus the UART time. Per register: 2 cycles of overhead.
- Ignored inputs:
  - i_dump_start while o_busy=1 (no restart, no queueing).
  - i_tx_done outside WAIT, including a done pulse in the same cycle as o_tx_start.
- Wrap-around: reg_cnt never exceeds NUM_REGS-1 and never wraps to 0 within a dump.
- Total bytes per dump: NUM_REGS*NB/8, which is 128 with the defaults.

Decomposition:
- Package debug_pkg holds:
  - the state enum, 3-bit encoded;
  - localparam BYTES_PER_WORD = NB/BYTE_NB;
  - byte counter width $clog2(BYTES_PER_WORD).
- One natural sub-module, debug_word_serializer.
  - Contains the shift register, byte counter, and the SEND/WAIT handshake.
  - Interface: load+word in; tx_start/tx_data/tx_done; word_done out.
- The top-level FSM owns the address counter, dump control and done.

Test Plan:
- Basic dump:
  - Register model returns 32'hA500_0000+k for address k, with 1-cycle latency; mock UART pulses i_tx_done 4 cycles after each tx_start.
  - Pulse i_dump_start.
  - Required: first tx_start at c3; bytes A5,00,00,00 then A5,00,00,01, ... ending A5,00,00,1F.
  - Required: exactly 128 tx_starts, one o_done pulse, then o_busy=0.
- Address sequencing:
  - Monitor o_select_reg_dir.
  - Required: it increments 0→31 once per 4 transmitted bytes and is stable through each word.
- Busy start:
  - Pulse i_dump_start again while on byte 10.
  - Required: still 128 bytes total; no restart.
- Spurious done:
  - Pulse i_tx_done in IDLE, and again coincident with o_tx_start.
  - Required: the byte sequence is unchanged and no byte is skipped.
- Reset mid-dump:
  - Drive i_reset=0 during register 5, without waiting for a clock.
  - Required: all outputs go to 0 immediately; no o_done.
  - After release, a new dump starts again at register 0 with byte A5.
- Back-to-back dumps with NUM_REGS=4:
  - Pulse i_dump_start in the cycle right after o_done.
  - Required: it is accepted; two full 16-byte sequences with two o_done pulses.
